// File: rtl/overlay_pkg.sv
// overlay_pkg: shared types and helpers for the text overlay compositor.
//   anim_state_t    - shadow offset animation direction (Rise/Fall)
//   DEFAULT_COORD_W - default pixel coordinate width
//   MAX_LAYERS      - widest layer vector the priority encoder accepts
//   id_width()      - width of a layer index (never below 1 bit)
//   prio_encode()   - index of the lowest set bit (0 when none set)
package overlay_pkg;

   typedef enum logic [0:0] {Rise, Fall} anim_state_t;

   localparam int unsigned DEFAULT_COORD_W = 10;
   localparam int unsigned MAX_LAYERS      = 32;

   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Lowest index wins: layer 0 has the highest priority.
   function automatic int unsigned prio_encode(input logic [MAX_LAYERS-1:0] hits);
      int unsigned idx;
      idx = 0;
      for (int i = MAX_LAYERS - 1; i >= 0; i--) begin
         if (hits[i]) idx = unsigned'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/shadow_anim.sv
// shadow_anim: per-frame shadow offset generator.
// A frame divider counts frame_start pulses; every FRAMES_PER_STEP pulses the
// offset steps up (Rise) towards SHADOW_MAX or down (Fall) towards 1. With
// ANIMATE=0 the divider and FSM are frozen and the offset is SHADOW_OFF.
// Optional macro OVERLAY_BLINK_EN adds a blink counter toggling blink_phase
// every BLINK_FRAMES frames (phase 1 = visible).
// Ports:
//   clk, rst     - pixel clock, synchronous active-high reset
//   frame_start  - one-cycle pulse per frame
//   shadow_off   - current shadow offset (changes only after a frame_start)
//   blink_phase  - (OVERLAY_BLINK_EN only) blink visibility phase
module shadow_anim
   import overlay_pkg::*;
#(
   parameter int unsigned SHADOW_W        = 3,
   parameter int unsigned SHADOW_OFF      = 4,
   parameter int unsigned SHADOW_MAX      = 6,
   parameter int unsigned ANIMATE         = 1,
   parameter int unsigned FRAMES_PER_STEP = 8
`ifdef OVERLAY_BLINK_EN
   ,
   parameter int unsigned BLINK_FRAMES    = 32
`endif
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                frame_start,
`ifdef OVERLAY_BLINK_EN
   output logic                blink_phase,
`endif
   output logic [SHADOW_W-1:0] shadow_off
);

   localparam int unsigned         DIV_W     = id_width(FRAMES_PER_STEP);
   localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(FRAMES_PER_STEP - 1);
   localparam logic [DIV_W-1:0]    DIV_ONE   = DIV_W'(1);
   localparam logic [SHADOW_W-1:0] OFF_ONE   = SHADOW_W'(1);
   localparam logic [SHADOW_W-1:0] OFF_MAX   = SHADOW_W'(SHADOW_MAX);
   localparam logic [SHADOW_W-1:0] RESET_OFF = (ANIMATE != 0) ? SHADOW_W'(1)
                                                              : SHADOW_W'(SHADOW_OFF);

   logic [DIV_W-1:0]    div_q;
   anim_state_t         state_q;
   logic [SHADOW_W-1:0] off_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q   <= '0;
         state_q <= Rise;
         off_q   <= RESET_OFF;
      end else if ((ANIMATE != 0) && frame_start) begin
         if (div_q == DIV_LAST) begin
            div_q <= '0;
            // Already at a bound (only possible when SHADOW_MAX=1): hold the
            // offset and just flip direction.
            unique case (state_q)
               Rise: begin
                  if (off_q >= OFF_MAX) begin
                     state_q <= Fall;
                  end else begin
                     off_q <= off_q + OFF_ONE;
                     if (off_q + OFF_ONE == OFF_MAX) state_q <= Fall;
                  end
               end
               Fall: begin
                  if (off_q <= OFF_ONE) begin
                     state_q <= Rise;
                  end else begin
                     off_q <= off_q - OFF_ONE;
                     if (off_q - OFF_ONE == OFF_ONE) state_q <= Rise;
                  end
               end
               default: state_q <= Rise;
            endcase
         end else begin
            div_q <= div_q + DIV_ONE;
         end
      end
   end

   assign shadow_off = off_q;

`ifdef OVERLAY_BLINK_EN
   localparam int unsigned      BLK_W    = id_width(BLINK_FRAMES);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
   localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);

   logic [BLK_W-1:0] blk_q;
   logic             phase_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         blk_q   <= '0;
         phase_q <= 1'b1;
      end else if (frame_start) begin
         if (blk_q == BLK_LAST) begin
            blk_q   <= '0;
            phase_q <= ~phase_q;
         end else begin
            blk_q <= blk_q + BLK_ONE;
         end
      end
   end

   assign blink_phase = phase_q;
`endif

endmodule

// File: rtl/overlay_compositor.sv
// overlay_compositor: two-stage text overlay pipeline.
// Stage 1 registers the pixel coordinate for the external main and shadow
// mask units (shadow coordinate offset by the animated shadow_off, modulo
// 2^COORD_W). Stage 2 combines the returned mask hits with the layer enables
// into text/overlay flags and a priority layer index. Latency is 2 cycles.
// Optional macro OVERLAY_BLINK_EN adds blink_sel and BLINK_FRAMES: while the
// blink phase is 0, layers selected by blink_sel are treated as disabled.
// Ports:
//   clk, rst                     - pixel clock, synchronous active-high reset
//   frame_start                  - frame pulse driving the offset animation
//   pix_valid, x, y              - input pixel coordinate
//   layer_en                     - per-layer enable (stage 2)
//   blink_sel                    - (OVERLAY_BLINK_EN only) layers that blink
//   mask_x/y_main, mask_x/y_shadow - stage-1 coordinates to mask units
//   main_mask, shadow_mask       - mask hits for the stage-1 coordinate
//   out_valid, text_active, overlay_active, layer_id - stage-2 results
//   shadow_off                   - current shadow offset
module overlay_compositor
   import overlay_pkg::*;
#(
   parameter int unsigned NUM_LAYERS      = 3,
   parameter int unsigned COORD_W         = DEFAULT_COORD_W,
   parameter int unsigned SHADOW_W        = 3,
   parameter int unsigned SHADOW_OFF      = 4,
   parameter int unsigned SHADOW_MAX      = 6,
   parameter int unsigned ANIMATE         = 1,
   parameter int unsigned FRAMES_PER_STEP = 8
`ifdef OVERLAY_BLINK_EN
   ,
   parameter int unsigned BLINK_FRAMES    = 32
`endif
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              frame_start,
   input  logic                              pix_valid,
   input  logic [COORD_W-1:0]                x,
   input  logic [COORD_W-1:0]                y,
   input  logic [NUM_LAYERS-1:0]             layer_en,
`ifdef OVERLAY_BLINK_EN
   input  logic [NUM_LAYERS-1:0]             blink_sel,
`endif
   output logic [COORD_W-1:0]                mask_x_main,
   output logic [COORD_W-1:0]                mask_y_main,
   output logic [COORD_W-1:0]                mask_x_shadow,
   output logic [COORD_W-1:0]                mask_y_shadow,
   input  logic [NUM_LAYERS-1:0]             main_mask,
   input  logic [NUM_LAYERS-1:0]             shadow_mask,
   output logic                              out_valid,
   output logic                              text_active,
   output logic                              overlay_active,
   output logic [id_width(NUM_LAYERS)-1:0]   layer_id,
   output logic [SHADOW_W-1:0]               shadow_off
);

   localparam int unsigned ID_W = id_width(NUM_LAYERS);

   logic [SHADOW_W-1:0]   off;
   logic                  v1_q;
   logic [NUM_LAYERS-1:0] gate_en;
   logic [NUM_LAYERS-1:0] main_hit;
   logic [NUM_LAYERS-1:0] shadow_hit;
   logic [MAX_LAYERS-1:0] main_w;
   logic [MAX_LAYERS-1:0] shadow_w;
   logic                  text_d;
   logic                  overlay_d;
   logic [ID_W-1:0]       id_d;

`ifdef OVERLAY_BLINK_EN
   logic blink_phase;

   shadow_anim #(
      .SHADOW_W        (SHADOW_W),
      .SHADOW_OFF      (SHADOW_OFF),
      .SHADOW_MAX      (SHADOW_MAX),
      .ANIMATE         (ANIMATE),
      .FRAMES_PER_STEP (FRAMES_PER_STEP),
      .BLINK_FRAMES    (BLINK_FRAMES)
   ) u_shadow_anim (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .blink_phase (blink_phase),
      .shadow_off  (off)
   );

   assign gate_en = layer_en & ~(blink_sel & {NUM_LAYERS{~blink_phase}});
`else
   shadow_anim #(
      .SHADOW_W        (SHADOW_W),
      .SHADOW_OFF      (SHADOW_OFF),
      .SHADOW_MAX      (SHADOW_MAX),
      .ANIMATE         (ANIMATE),
      .FRAMES_PER_STEP (FRAMES_PER_STEP)
   ) u_shadow_anim (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .shadow_off  (off)
   );

   assign gate_en = layer_en;
`endif

   assign shadow_off = off;

   // Stage 1: coordinates to the mask units. The offset register only moves
   // on the frame_start edge, so a coinciding pixel still sees the old value.
   always_ff @(posedge clk) begin
      if (rst) begin
         mask_x_main   <= '0;
         mask_y_main   <= '0;
         mask_x_shadow <= '0;
         mask_y_shadow <= '0;
         v1_q          <= 1'b0;
      end else begin
         mask_x_main   <= x;
         mask_y_main   <= y;
         mask_x_shadow <= x - COORD_W'(off);
         mask_y_shadow <= y - COORD_W'(off);
         v1_q          <= pix_valid;
      end
   end

   always_comb begin
      main_hit   = main_mask & gate_en;
      shadow_hit = shadow_mask & gate_en;
      main_w     = '0;
      shadow_w   = '0;
      main_w[NUM_LAYERS-1:0]   = main_hit;
      shadow_w[NUM_LAYERS-1:0] = shadow_hit;
      text_d    = v1_q & (|main_hit);
      overlay_d = v1_q & ((|main_hit) | (|shadow_hit));
      id_d      = '0;
      // Any main hit outranks every shadow hit.
      if (v1_q) begin
         if (|main_hit) begin
            id_d = ID_W'(prio_encode(main_w));
         end else if (|shadow_hit) begin
            id_d = ID_W'(prio_encode(shadow_w));
         end
      end
   end

   // Stage 2: registered flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid      <= 1'b0;
         text_active    <= 1'b0;
         overlay_active <= 1'b0;
         layer_id       <= '0;
      end else begin
         out_valid      <= v1_q;
         text_active    <= text_d;
         overlay_active <= overlay_d;
         layer_id       <= id_d;
      end
   end

endmodule

// File: tb/tb_overlay_compositor.sv
// Directed bench for overlay_compositor. Two instances share stimulus:
// u_static (ANIMATE=0, SHADOW_OFF=4) and u_anim (ANIMATE=1,
// FRAMES_PER_STEP=2, SHADOW_MAX=3, BLINK_FRAMES=2 under OVERLAY_BLINK_EN).
module tb_overlay_compositor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       frame_start;
   logic       pix_valid;
   logic [9:0] x;
   logic [9:0] y;
   logic [2:0] layer_en;
   logic [2:0] main_mask;
   logic [2:0] shadow_mask;
`ifdef OVERLAY_BLINK_EN
   logic [2:0] blink_sel;
`endif

   logic [9:0] s_mxm, s_mym, s_mxs, s_mys;
   logic       s_out_valid, s_text, s_overlay;
   logic [1:0] s_layer_id;
   logic [2:0] s_shadow_off;

   logic [9:0] a_mxm, a_mym, a_mxs, a_mys;
   logic       a_out_valid, a_text, a_overlay;
   logic [1:0] a_layer_id;
   logic [2:0] a_shadow_off;

   int vectors     = 0;
   int miscompares = 0;

   overlay_compositor #(
      .ANIMATE    (0),
      .SHADOW_OFF (4)
   ) u_static (
      .clk            (clk),
      .rst            (rst),
      .frame_start    (frame_start),
      .pix_valid      (pix_valid),
      .x              (x),
      .y              (y),
      .layer_en       (layer_en),
`ifdef OVERLAY_BLINK_EN
      .blink_sel      (blink_sel),
`endif
      .mask_x_main    (s_mxm),
      .mask_y_main    (s_mym),
      .mask_x_shadow  (s_mxs),
      .mask_y_shadow  (s_mys),
      .main_mask      (main_mask),
      .shadow_mask    (shadow_mask),
      .out_valid      (s_out_valid),
      .text_active    (s_text),
      .overlay_active (s_overlay),
      .layer_id       (s_layer_id),
      .shadow_off     (s_shadow_off)
   );

   overlay_compositor #(
      .ANIMATE         (1),
      .FRAMES_PER_STEP (2),
      .SHADOW_MAX      (3)
`ifdef OVERLAY_BLINK_EN
      ,
      .BLINK_FRAMES    (2)
`endif
   ) u_anim (
      .clk            (clk),
      .rst            (rst),
      .frame_start    (frame_start),
      .pix_valid      (pix_valid),
      .x              (x),
      .y              (y),
      .layer_en       (layer_en),
`ifdef OVERLAY_BLINK_EN
      .blink_sel      (blink_sel),
`endif
      .mask_x_main    (a_mxm),
      .mask_y_main    (a_mym),
      .mask_x_shadow  (a_mxs),
      .mask_y_shadow  (a_mys),
      .main_mask      (main_mask),
      .shadow_mask    (shadow_mask),
      .out_valid      (a_out_valid),
      .text_active    (a_text),
      .overlay_active (a_overlay),
      .layer_id       (a_layer_id),
      .shadow_off     (a_shadow_off)
   );

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Advance one clock; sample 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int seq [7] = '{1, 2, 3, 2, 1, 2, 3};

   initial begin
      rst         = 1'b1;
      frame_start = 1'b0;
      pix_valid   = 1'b0;
      x           = '0;
      y           = '0;
      layer_en    = 3'b111;
      main_mask   = '0;
      shadow_mask = '0;
`ifdef OVERLAY_BLINK_EN
      blink_sel   = '0;
`endif
      tick();
      tick();

      // Reset state
      check("rst_out_valid", 32'(s_out_valid), 0);
      check("rst_text", 32'(s_text), 0);
      check("rst_overlay", 32'(s_overlay), 0);
      check("rst_layer_id", 32'(s_layer_id), 0);
      check("rst_mask_x_shadow", 32'(s_mxs), 0);
      check("rst_static_off", 32'(s_shadow_off), 4);
      check("rst_anim_off", 32'(a_shadow_off), 1);

      // Static offset: x=100, y=50
      rst       = 1'b0;
      pix_valid = 1'b1;
      x         = 10'd100;
      y         = 10'd50;
      tick();
      check("s1_mask_x_main", 32'(s_mxm), 100);
      check("s1_mask_y_main", 32'(s_mym), 50);
      check("s1_mask_x_shadow", 32'(s_mxs), 96);
      check("s1_mask_y_shadow", 32'(s_mys), 46);
      main_mask   = 3'b000;
      shadow_mask = 3'b010;
      pix_valid   = 1'b0;
      tick();
      check("s2_out_valid", 32'(s_out_valid), 1);
      check("s2_overlay", 32'(s_overlay), 1);
      check("s2_text", 32'(s_text), 0);
      check("s2_layer_id", 32'(s_layer_id), 1);

      // Wrap of the shadow coordinate
      pix_valid   = 1'b1;
      x           = 10'd2;
      y           = 10'd1;
      main_mask   = 3'b000;
      shadow_mask = 3'b000;
      tick();
      check("wrap_x_shadow", 32'(s_mxs), 1022);
      check("wrap_y_shadow", 32'(s_mys), 1021);

      // Priority with enables
      main_mask = 3'b110;
      layer_en  = 3'b011;
      pix_valid = 1'b1;
      x         = 10'd5;
      y         = 10'd5;
      tick();
      check("prio_layer_id", 32'(s_layer_id), 1);
      check("prio_text", 32'(s_text), 1);
      check("prio_overlay", 32'(s_overlay), 1);

      // All layers disabled: flags 0 while valid stays
      main_mask   = 3'b110;
      shadow_mask = 3'b111;
      layer_en    = 3'b000;
      pix_valid   = 1'b0;
      tick();
      check("dis_out_valid", 32'(s_out_valid), 1);
      check("dis_text", 32'(s_text), 0);
      check("dis_overlay", 32'(s_overlay), 0);
      check("dis_layer_id", 32'(s_layer_id), 0);

      // Bubble: hits present but v1=0
      layer_en = 3'b111;
      tick();
      check("bub_out_valid", 32'(s_out_valid), 0);
      check("bub_overlay", 32'(s_overlay), 0);
      check("bub_text", 32'(s_text), 0);

      // Shadow-only priority, then main outranks lower-index shadow
      pix_valid   = 1'b1;
      tick();
      main_mask   = 3'b000;
      shadow_mask = 3'b110;
      tick();
      check("shprio_layer_id", 32'(s_layer_id), 1);
      check("shprio_text", 32'(s_text), 0);
      main_mask   = 3'b100;
      shadow_mask = 3'b011;
      tick();
      check("mainwin_layer_id", 32'(s_layer_id), 2);
      check("mainwin_text", 32'(s_text), 1);

      // Animation: 12 pulses, pixel coinciding with each pulse
      main_mask   = 3'b000;
      shadow_mask = 3'b000;
      for (int p = 1; p <= 12; p++) begin
         frame_start = 1'b1;
         pix_valid   = 1'b1;
         x           = 10'd100;
         y           = 10'd100;
         tick();
         frame_start = 1'b0;
         pix_valid   = 1'b0;
         check("anim_off_pulse", 32'(a_shadow_off), 32'(seq[p / 2]));
         check("anim_pre_update_x", 32'(a_mxs), 32'(100 - seq[(p - 1) / 2]));
         tick();
         tick();
         check("anim_off_hold", 32'(a_shadow_off), 32'(seq[p / 2]));
      end
      check("static_off_held", 32'(s_shadow_off), 4);

      // Reset mid-stream
      pix_valid = 1'b1;
      main_mask = 3'b001;
      tick();
      tick();
      check("run_out_valid", 32'(s_out_valid), 1);
      check("run_text", 32'(s_text), 1);
      rst = 1'b1;
      tick();
      check("mrst_s_out_valid", 32'(s_out_valid), 0);
      check("mrst_a_out_valid", 32'(a_out_valid), 0);
      check("mrst_s_text", 32'(s_text), 0);
      check("mrst_anim_off", 32'(a_shadow_off), 1);
      check("mrst_static_off", 32'(s_shadow_off), 4);
      check("mrst_mask_x_main", 32'(s_mxm), 0);
      rst       = 1'b0;
      pix_valid = 1'b1;
      x         = 10'd7;
      tick();
      check("post_rst_lat1", 32'(s_out_valid), 0);
      pix_valid = 1'b0;
      tick();
      check("post_rst_lat2", 32'(s_out_valid), 1);
      tick();
      check("post_rst_bubble", 32'(s_out_valid), 0);

`ifdef OVERLAY_BLINK_EN
      // Blink: counter and phase freshly reset above
      blink_sel   = 3'b001;
      main_mask   = 3'b001;
      shadow_mask = 3'b000;
      layer_en    = 3'b111;
      pix_valid   = 1'b1;
      for (int f = 0; f < 5; f++) begin
         tick();
         tick();
         tick();
         check("blink_text", 32'(a_text), (((f / 2) % 2) == 0) ? 32'd1 : 32'd0);
         frame_start = 1'b1;
         tick();
         frame_start = 1'b0;
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
